dl_fpu_rob: RTL and testbench
=============================

Name: dl_fpu_rob

Overview:
- Parametrised issue/completion controller for the DLFloat16 FPU.
- Successor to the flat per-unit output mux: accepts FPU ops with valid/ready and allocates a tag per op.
- Dispatches each op to one of NUM_UNITS execution units; those units may finish out of order and with variable latency.
- Retires results strictly in program order to the rounding stage, and accumulates sticky exception flags.

Parameters:
- NUM_UNITS, 5, number of execution units (add_sub, mul, div, sqrt, mac by default).
- DEPTH, 8, reorder entries; power of two, 2..64.
- DW, 32, result width carried per entry.
- UW, 3, unit-select width; must satisfy 2**UW > NUM_UNITS - 1.
- TAGW, $clog2(DEPTH), derived; not overridable.

Ports:
- clk  in  1  clock; all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  op request.
- in_ready  out  1  op accepted when in_valid&in_ready.
- in_unit  in  UW  target unit index.
- in_rm  in  3  rounding mode carried with the op.
- iss_valid  out  NUM_UNITS  one-hot issue strobe to units.
- iss_ready  in  NUM_UNITS  unit can accept.
- iss_tag  out  TAGW  tag of issued op; shared by all units.
- cmp_valid  in  NUM_UNITS  per-unit completion strobe.
- cmp_tag  in  NUM_UNITS*TAGW  completing tag, unit u at [u*TAGW+:TAGW].
- cmp_data  in  NUM_UNITS*DW  result.
- cmp_exc  in  NUM_UNITS*5  exceptions {NV,DZ,OF,UF,NX}.
- out_valid  out  1  head result available.
- out_ready  in  1  downstream accepts.
- out_result  out  DW  head result.
- out_rm  out  3  head rounding mode.
- out_exc  out  5  head exceptions.
- fflags  out  5  sticky OR of retired out_exc.
- fflags_clr  in  1  clear fflags.
- busy  out  1  any entry allocated.
- err  out  1  sticky protocol-error flag.

Behaviour:
- **State:**
  - Circular buffer of DEPTH entries {done, data, exc, rm}.
  - head/tail pointers of TAGW+1 bits; the MSB is the wrap bit.
  - full = (head^tail)==1<<TAGW; empty = head==tail.
- **Reset:**
  - head=tail=0, all done=0, fflags=0, err=0.
  - Outputs after reset: out_valid=0, busy=0, iss_valid=0.
  - in_ready=0 while rst is high.
  - Reset mid-operation discards all in-flight entries; completions arriving in the first cycle after reset are handled as spurious (see Completion).
- **Accept:**
  - in_ready = !rst & !full & (in_unit>=NUM_UNITS | iss_ready[in_unit]).
  - in_ready uses full before the same-cycle retire; there is no retire-to-accept bypass.
- **Issue (combinational):**
  - iss_valid[u] = in_valid&in_ready&(in_unit==u).
  - iss_tag = tail[TAGW-1:0].
  - On accept: entry[tail].rm <= in_rm, entry[tail].done <= 0, tail++.
- **Invalid unit (in_unit>=NUM_UNITS):**
  - The op is accepted with no iss_valid.
  - Its entry is written with done=1, data=0, exc=5'b10000 (NV).
- **Completion:**
  - For each u with cmp_valid[u] whose tag is allocated and not done: write data and exc, set done=1.
  - Allocated means inside [head, tail) modulo wrap.
  - A tag that is unallocated or already done is spurious: the write is ignored and err<=1.
  - Two units completing the same tag in one cycle: the lowest u wins, the others are ignored, and err<=1.
- **Retire:**
  - out_valid = !empty & entry[head].done; out_result, out_exc and out_rm come from entry[head] (combinational from the array).
  - A completion into the head entry in cycle N gives out_valid in cycle N+1; there is no same-cycle bypass.
  - out_valid&out_ready: clear entry[head].done, head++, fflags <= fflags | out_exc.
  - With out_ready=0, out_* hold stable.
- **fflags:**
  - fflags_clr alone: fflags <= 0.
  - fflags_clr together with a retire: fflags <= out_exc (clear first, then OR).
- **Other outputs:**
  - busy = !empty.
  - err clears only on rst.
- **Simultaneous events:** accept, multiple completions and a retire may all occur in one cycle; each acts on distinct entry fields as above.

Decomposition:
- **Shared package dl_fpu_pkg:**
  - Exception bit indices: NV=4, DZ=3, OF=2, UF=1, NX=0.
  - EXW=5.
  - Rounding-mode encodings: RNE 000, RTZ 001, RDN 010, RUP 011, RMM 100, DYN 111.
  - Unit indices: ADD_SUB=0, MUL=1, DIV=2, SQRT=3, MAC=4.
- **Sub-module dl_wrap_ptr:** TAGW+1-bit pointer with increment enable and synchronous reset; instanced for head and tail.

Test Plan:
- **In-order single op:** rst 2 cycles; issue unit 1 rm=000 (tag 0); two cycles later cmp_valid[1], tag 0, data 32'h00004100, exc 0 → out_valid=1 the next cycle with result 32'h00004100; retire → busy=0, fflags=0.
- **Out-of-order completion:** issue unit 2 (tag 0) then unit 0 (tag 1); complete tag 1 first with exc NX → out_valid stays 0; complete tag 0 exc 0 → retire order tag0 then tag1; fflags=5'b00001.
- **Full:** 8 accepts with no completions → in_ready=0 after the 8th; complete and retire the head → in_ready=1 the cycle after the retire; the next op gets tag 0 with the wrap bit set.
- **Backpressure and clear:** out_ready=0 for 5 cycles → out_result and out_exc stable, busy=1; fflags_clr in the same cycle as retire of exc OF → fflags=5'b00100.
- **Invalid unit:** in_unit=6 → no iss_valid; entry retires with result 0 and exc 5'b10000.
- **Protocol errors:** completion for an unallocated tag 3 → err=1, no other state change; units 0 and 1 completing the same tag → data from unit 0, err=1; rst mid-flight → busy=0, fflags=0 next cycle.

Source files
------------

// File: rtl/dl_fpu_pkg.sv
// Shared DLFloat16 FPU definitions: exception flag layout, rounding modes and
// execution-unit indices used by the issue/retire controller.
package dl_fpu_pkg;

  localparam int EXW = 5;

  localparam int EXC_NV = 4;
  localparam int EXC_DZ = 3;
  localparam int EXC_OF = 2;
  localparam int EXC_UF = 1;
  localparam int EXC_NX = 0;

  // Flags reported for an op routed to a unit index that does not exist
  localparam logic [EXW-1:0] EXC_INVALID = EXW'(1 << EXC_NV);

  typedef enum logic [2:0] {
    RM_RNE = 3'b000,
    RM_RTZ = 3'b001,
    RM_RDN = 3'b010,
    RM_RUP = 3'b011,
    RM_RMM = 3'b100,
    RM_DYN = 3'b111
  } rm_e;

  localparam int UNIT_ADD_SUB = 0;
  localparam int UNIT_MUL     = 1;
  localparam int UNIT_DIV     = 2;
  localparam int UNIT_SQRT    = 3;
  localparam int UNIT_MAC     = 4;

endpackage

// File: rtl/dl_wrap_ptr.sv
// Circular-buffer pointer: index bits plus one wrap bit, so that full and
// empty can be told apart when the index bits are equal.
module dl_wrap_ptr #(
  parameter int PW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          inc,
  output logic [PW-1:0] ptr
);

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (inc) begin
      ptr <= ptr + PW'(1);
    end
  end

endmodule

// File: rtl/dl_fpu_rob.sv
// Issue/completion controller for the DLFloat16 FPU: tags ops in program order,
// accepts out-of-order unit completions and retires results strictly in order.
module dl_fpu_rob
  import dl_fpu_pkg::*;
#(
  parameter  int NUM_UNITS = 5,
  parameter  int DEPTH     = 8,
  parameter  int DW        = 32,
  parameter  int UW        = 3,
  localparam int TAGW      = $clog2(DEPTH)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [UW-1:0]             in_unit,
  input  logic [2:0]                in_rm,
  output logic [NUM_UNITS-1:0]      iss_valid,
  input  logic [NUM_UNITS-1:0]      iss_ready,
  output logic [TAGW-1:0]           iss_tag,
  input  logic [NUM_UNITS-1:0]      cmp_valid,
  input  logic [NUM_UNITS*TAGW-1:0] cmp_tag,
  input  logic [NUM_UNITS*DW-1:0]   cmp_data,
  input  logic [NUM_UNITS*EXW-1:0]  cmp_exc,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DW-1:0]             out_result,
  output logic [2:0]                out_rm,
  output logic [EXW-1:0]            out_exc,
  output logic [EXW-1:0]            fflags,
  input  logic                      fflags_clr,
  output logic                      busy,
  output logic                      err
);

  localparam int PW = TAGW + 1;

  logic [PW-1:0]        head, tail, count;
  logic [TAGW-1:0]      head_idx, tail_idx;
  logic                 full, empty, accept, retire;
  logic                 unit_invalid, unit_ok;
  logic [NUM_UNITS-1:0] unit_hit, cmp_we, cmp_spur;

  logic [DEPTH-1:0]     done_q;
  logic [DW-1:0]        data_q [DEPTH];
  logic [EXW-1:0]       exc_q  [DEPTH];
  logic [2:0]           rm_q   [DEPTH];

  dl_wrap_ptr #(.PW(PW)) u_head_ptr (.clk(clk), .rst(rst), .inc(retire), .ptr(head));
  dl_wrap_ptr #(.PW(PW)) u_tail_ptr (.clk(clk), .rst(rst), .inc(accept), .ptr(tail));

  assign head_idx = head[TAGW-1:0];
  assign tail_idx = tail[TAGW-1:0];
  assign count    = tail - head;
  assign empty    = (head == tail);
  assign full     = ((head ^ tail) == {1'b1, {TAGW{1'b0}}});

  // Ops aimed at a nonexistent unit never wait on a unit's ready
  assign unit_invalid = (32'(in_unit) >= NUM_UNITS);

  always_comb begin
    unit_hit = '0;
    unit_ok  = unit_invalid;
    for (int u = 0; u < NUM_UNITS; u++) begin
      unit_hit[u] = (in_unit == UW'(u));
      unit_ok     = unit_ok | (unit_hit[u] & iss_ready[u]);
    end
  end

  assign in_ready  = !rst & !full & unit_ok;
  assign accept    = in_valid & in_ready;
  assign iss_valid = accept ? unit_hit : '0;
  assign iss_tag   = tail_idx;

  // A completion lands only on an allocated, not-yet-done tag that no lower
  // unit is also completing this cycle; anything else is a protocol error.
  always_comb begin
    logic [TAGW-1:0] tag_u;
    logic            alloc;
    logic            dup;
    cmp_we   = '0;
    cmp_spur = '0;
    tag_u    = '0;
    alloc    = 1'b0;
    dup      = 1'b0;
    for (int u = 0; u < NUM_UNITS; u++) begin
      tag_u = cmp_tag[u*TAGW +: TAGW];
      alloc = ({1'b0, tag_u - head_idx} < count);
      dup   = 1'b0;
      for (int v = 0; v < u; v++) begin
        if (cmp_valid[v] && (cmp_tag[v*TAGW +: TAGW] == tag_u)) begin
          dup = 1'b1;
        end
      end
      cmp_we[u]   = cmp_valid[u] & alloc & !done_q[tag_u] & !dup;
      cmp_spur[u] = cmp_valid[u] & !cmp_we[u];
    end
  end

  assign out_valid  = !empty & done_q[head_idx];
  assign out_result = data_q[head_idx];
  assign out_exc    = exc_q[head_idx];
  assign out_rm     = rm_q[head_idx];
  assign retire     = out_valid & out_ready;
  assign busy       = !empty;

  // Retire, completions and accept always touch distinct entries
  always_ff @(posedge clk) begin
    if (rst) begin
      done_q <= '0;
    end else begin
      if (retire) begin
        done_q[head_idx] <= 1'b0;
      end
      for (int u = 0; u < NUM_UNITS; u++) begin
        if (cmp_we[u]) begin
          done_q[cmp_tag[u*TAGW +: TAGW]] <= 1'b1;
        end
      end
      if (accept) begin
        done_q[tail_idx] <= unit_invalid;
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int u = 0; u < NUM_UNITS; u++) begin
      if (cmp_we[u]) begin
        data_q[cmp_tag[u*TAGW +: TAGW]] <= cmp_data[u*DW +: DW];
        exc_q[cmp_tag[u*TAGW +: TAGW]]  <= cmp_exc[u*EXW +: EXW];
      end
    end
    if (accept) begin
      rm_q[tail_idx] <= in_rm;
      if (unit_invalid) begin
        data_q[tail_idx] <= '0;
        exc_q[tail_idx]  <= EXC_INVALID;
      end
    end
  end

  // A clear in the same cycle as a retire keeps only the retiring flags
  always_ff @(posedge clk) begin
    if (rst) begin
      fflags <= '0;
      err    <= 1'b0;
    end else begin
      if (fflags_clr) begin
        fflags <= retire ? out_exc : '0;
      end else if (retire) begin
        fflags <= fflags | out_exc;
      end
      if (|cmp_spur) begin
        err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_dl_fpu_rob.sv
// Scoreboard bench for dl_fpu_rob: expected retire payloads are queued at issue
// time and popped when the controller hands a result to the rounding stage.
module tb_dl_fpu_rob;
  import dl_fpu_pkg::*;

  localparam int NU   = 5;
  localparam int DW   = 32;
  localparam int UW   = 3;
  localparam int TAGW = 3;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid, in_ready;
  logic [UW-1:0]    in_unit;
  logic [2:0]       in_rm;
  logic [NU-1:0]    iss_valid, iss_ready;
  logic [TAGW-1:0]  iss_tag;
  logic [NU-1:0]    cmp_valid;
  logic [NU*TAGW-1:0] cmp_tag;
  logic [NU*DW-1:0] cmp_data;
  logic [NU*5-1:0]  cmp_exc;
  logic             out_valid, out_ready;
  logic [DW-1:0]    out_result;
  logic [2:0]       out_rm;
  logic [4:0]       out_exc, fflags;
  logic             fflags_clr, busy, err;

  typedef struct {
    logic [31:0] data;
    logic [4:0]  exc;
    logic [2:0]  rm;
  } exp_t;

  exp_t sb[$];
  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  dl_fpu_rob #(.NUM_UNITS(NU), .DEPTH(8), .DW(DW), .UW(UW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_unit(in_unit), .in_rm(in_rm),
    .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_tag(iss_tag),
    .cmp_valid(cmp_valid), .cmp_tag(cmp_tag), .cmp_data(cmp_data), .cmp_exc(cmp_exc),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_rm(out_rm), .out_exc(out_exc),
    .fflags(fflags), .fflags_clr(fflags_clr), .busy(busy), .err(err)
  );

  function automatic exp_t mk(input logic [31:0] d, input logic [4:0] e, input logic [2:0] r);
    exp_t x;
    x.data = d;
    x.exc  = e;
    x.rm   = r;
    return x;
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0; in_unit = '0; in_rm = '0;
    iss_ready = '1; cmp_valid = '0; cmp_tag = '0; cmp_data = '0; cmp_exc = '0;
    out_ready = 1'b0; fflags_clr = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    sb.delete();
  endtask

  task automatic do_issue(input logic [2:0] unit, input logic [2:0] rm,
                          output logic [TAGW-1:0] tag, output logic [NU-1:0] iv);
    in_valid = 1'b1; in_unit = unit; in_rm = rm;
    #1;
    for (int i = 0; i < 20 && !in_ready; i++) begin
      @(negedge clk); #1;
    end
    vectors++;
    if (in_ready !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL issue_timeout: in_ready=%b, required 1", in_ready);
    end
    tag = iss_tag;
    iv  = iss_valid;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic do_complete(input int unit, input logic [TAGW-1:0] tag,
                             input logic [31:0] data, input logic [4:0] exc);
    cmp_valid = '0;
    cmp_valid[unit] = 1'b1;
    cmp_tag[unit*TAGW +: TAGW] = tag;
    cmp_data[unit*DW +: DW] = data;
    cmp_exc[unit*5 +: 5] = exc;
    @(negedge clk);
    cmp_valid = '0;
  endtask

  task automatic do_retire(output logic [31:0] d, output logic [4:0] e, output logic [2:0] r);
    out_ready = 1'b1;
    #1;
    for (int i = 0; i < 20 && !out_valid; i++) begin
      @(negedge clk); #1;
    end
    vectors++;
    if (out_valid !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL retire_timeout: out_valid=%b, required 1", out_valid);
    end
    d = out_result; e = out_exc; r = out_rm;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    rst = 1'b1;
    in_valid = 1'b0; in_unit = 3'd1; in_rm = '0;
    iss_ready = '1; cmp_valid = '0; cmp_tag = '0; cmp_data = '0; cmp_exc = '0;
    out_ready = 1'b0; fflags_clr = 1'b0;
    @(negedge clk); #1;
    vectors++;
    if (in_ready !== 1'b0) begin
      miscompares++; $display("[TB] FAIL in_ready_in_reset: got %b, required 0", in_ready);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    d = {24'd0, out_valid, busy, err, fflags};
    vectors++;
    if (d !== 32'd0) begin
      miscompares++; $display("[TB] FAIL reset_state {ov,busy,err,fflags}: got %h, required 0", d);
    end
    vectors++;
    if ({in_ready, iss_valid} !== {1'b1, 5'b00000}) begin
      miscompares++; $display("[TB] FAIL ready_after_reset: got %b/%b, required 1/00000", in_ready, iss_valid);
    end
  endtask

  task automatic test_in_order();
    logic [TAGW-1:0] tag; logic [NU-1:0] iv;
    logic [31:0] d; logic [4:0] e; logic [2:0] r; exp_t x;
    do_reset();
    do_issue(3'(UNIT_MUL), RM_RNE, tag, iv);
    sb.push_back(mk(32'h0000_4100, 5'b00000, RM_RNE));
    vectors++;
    if ({tag, iv} !== {3'd0, 5'b00010}) begin
      miscompares++; $display("[TB] FAIL inorder_issue tag/iss_valid: got %0d/%b, required 0/00010", tag, iv);
    end
    @(negedge clk);
    cmp_valid[UNIT_MUL] = 1'b1;
    cmp_tag[UNIT_MUL*TAGW +: TAGW] = 3'd0;
    cmp_data[UNIT_MUL*DW +: DW] = 32'h0000_4100;
    cmp_exc[UNIT_MUL*5 +: 5] = 5'b00000;
    #1;
    vectors++;
    if (out_valid !== 1'b0) begin
      miscompares++; $display("[TB] FAIL no_bypass out_valid: got %b, required 0", out_valid);
    end
    @(negedge clk);
    cmp_valid = '0;
    #1;
    vectors++;
    if (out_valid !== 1'b1) begin
      miscompares++; $display("[TB] FAIL valid_after_cmp: got %b, required 1", out_valid);
    end
    do_retire(d, e, r);
    x = sb.pop_front();
    vectors++;
    if ({d, e, r} !== {x.data, x.exc, x.rm}) begin
      miscompares++; $display("[TB] FAIL inorder_retire: got %h/%b/%b, required %h/%b/%b", d, e, r, x.data, x.exc, x.rm);
    end
    #1;
    vectors++;
    if ({busy, fflags} !== 6'd0) begin
      miscompares++; $display("[TB] FAIL inorder_idle busy/fflags: got %b/%b, required 0/00000", busy, fflags);
    end
  endtask

  task automatic test_out_of_order();
    logic [TAGW-1:0] tag; logic [NU-1:0] iv;
    logic [31:0] d; logic [4:0] e; logic [2:0] r; exp_t x;
    do_reset();
    do_issue(3'(UNIT_DIV), RM_RTZ, tag, iv);
    sb.push_back(mk(32'h0000_3C00, 5'b00000, RM_RTZ));
    do_issue(3'(UNIT_ADD_SUB), RM_RDN, tag, iv);
    sb.push_back(mk(32'h0000_4200, 5'b00001, RM_RDN));
    vectors++;
    if ({tag, iv} !== {3'd1, 5'b00001}) begin
      miscompares++; $display("[TB] FAIL ooo_second_issue tag/iss_valid: got %0d/%b, required 1/00001", tag, iv);
    end
    do_complete(UNIT_ADD_SUB, 3'd1, 32'h0000_4200, 5'b00001);
    #1;
    vectors++;
    if (out_valid !== 1'b0) begin
      miscompares++; $display("[TB] FAIL ooo_hold out_valid: got %b, required 0", out_valid);
    end
    do_complete(UNIT_DIV, 3'd0, 32'h0000_3C00, 5'b00000);
    for (int k = 0; k < 2; k++) begin
      do_retire(d, e, r);
      x = sb.pop_front();
      vectors++;
      if ({d, e, r} !== {x.data, x.exc, x.rm}) begin
        miscompares++; $display("[TB] FAIL ooo_retire%0d: got %h/%b/%b, required %h/%b/%b", k, d, e, r, x.data, x.exc, x.rm);
      end
    end
    #1;
    vectors++;
    if ({busy, fflags} !== {1'b0, 5'b00001}) begin
      miscompares++; $display("[TB] FAIL ooo_fflags busy/fflags: got %b/%b, required 0/00001", busy, fflags);
    end
  endtask

  task automatic test_full();
    logic [TAGW-1:0] tag; logic [NU-1:0] iv;
    logic [31:0] d; logic [4:0] e; logic [2:0] r; exp_t x;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      do_issue(3'(UNIT_ADD_SUB), RM_RNE, tag, iv);
      sb.push_back(mk(32'h100 + 32'(i), 5'b00000, RM_RNE));
      vectors++;
      if (tag !== 3'(i)) begin
        miscompares++; $display("[TB] FAIL full_fill_tag%0d: got %0d, required %0d", i, tag, i);
      end
    end
    #1;
    vectors++;
    if ({in_ready, busy} !== 2'b01) begin
      miscompares++; $display("[TB] FAIL full_in_ready/busy: got %b/%b, required 0/1", in_ready, busy);
    end
    do_complete(UNIT_ADD_SUB, 3'd0, 32'h100, 5'b00000);
    out_ready = 1'b1;
    #1;
    vectors++;
    if ({out_valid, in_ready} !== 2'b10) begin
      miscompares++; $display("[TB] FAIL full_retire_cycle out_valid/in_ready: got %b/%b, required 1/0", out_valid, in_ready);
    end
    d = out_result; e = out_exc; r = out_rm;
    @(negedge clk);
    out_ready = 1'b0;
    #1;
    vectors++;
    if (in_ready !== 1'b1) begin
      miscompares++; $display("[TB] FAIL ready_after_retire: got %b, required 1", in_ready);
    end
    x = sb.pop_front();
    vectors++;
    if ({d, e, r} !== {x.data, x.exc, x.rm}) begin
      miscompares++; $display("[TB] FAIL full_retire: got %h/%b/%b, required %h/%b/%b", d, e, r, x.data, x.exc, x.rm);
    end
    do_issue(3'(UNIT_SQRT), RM_RMM, tag, iv);
    vectors++;
    if ({tag, iv} !== {3'd0, 5'b01000}) begin
      miscompares++; $display("[TB] FAIL wrap_tag tag/iss_valid: got %0d/%b, required 0/01000", tag, iv);
    end
    #1;
    vectors++;
    if (in_ready !== 1'b0) begin
      miscompares++; $display("[TB] FAIL refull_in_ready: got %b, required 0", in_ready);
    end
  endtask

  task automatic test_backpressure();
    logic [TAGW-1:0] tag; logic [NU-1:0] iv;
    logic [31:0] d; logic [4:0] e; logic [2:0] r; exp_t x;
    do_reset();
    do_issue(3'(UNIT_MUL), RM_RUP, tag, iv);
    sb.push_back(mk(32'h0000_1111, 5'b00001, RM_RUP));
    do_issue(3'(UNIT_MUL), RM_RUP, tag, iv);
    sb.push_back(mk(32'h0000_1234, 5'b00100, RM_RUP));
    do_complete(UNIT_MUL, 3'd0, 32'h0000_1111, 5'b00001);
    do_complete(UNIT_MUL, 3'd1, 32'h0000_1234, 5'b00100);
    do_retire(d, e, r);
    x = sb.pop_front();
    vectors++;
    if ({d, e, r} !== {x.data, x.exc, x.rm}) begin
      miscompares++; $display("[TB] FAIL bp_first_retire: got %h/%b/%b, required %h/%b/%b", d, e, r, x.data, x.exc, x.rm);
    end
    #1;
    vectors++;
    if (fflags !== 5'b00001) begin
      miscompares++; $display("[TB] FAIL bp_fflags_nx: got %b, required 00001", fflags);
    end
    for (int k = 0; k < 5; k++) begin
      vectors++;
      if ({out_valid, busy, out_result, out_exc} !== {1'b1, 1'b1, 32'h0000_1234, 5'b00100}) begin
        miscompares++; $display("[TB] FAIL bp_hold%0d ov/busy/result/exc: got %b/%b/%h/%b, required 1/1/00001234/00100",
                                k, out_valid, busy, out_result, out_exc);
      end
      @(negedge clk); #1;
    end
    out_ready = 1'b1; fflags_clr = 1'b1;
    #1;
    d = out_result; e = out_exc; r = out_rm;
    @(negedge clk);
    out_ready = 1'b0; fflags_clr = 1'b0;
    #1;
    x = sb.pop_front();
    vectors++;
    if ({d, e, r} !== {x.data, x.exc, x.rm}) begin
      miscompares++; $display("[TB] FAIL bp_second_retire: got %h/%b/%b, required %h/%b/%b", d, e, r, x.data, x.exc, x.rm);
    end
    vectors++;
    if (fflags !== 5'b00100) begin
      miscompares++; $display("[TB] FAIL clr_with_retire fflags: got %b, required 00100", fflags);
    end
    fflags_clr = 1'b1;
    @(negedge clk);
    fflags_clr = 1'b0;
    #1;
    vectors++;
    if (fflags !== 5'b00000) begin
      miscompares++; $display("[TB] FAIL clr_alone fflags: got %b, required 00000", fflags);
    end
  endtask

  task automatic test_invalid_unit();
    logic [TAGW-1:0] tag; logic [NU-1:0] iv;
    logic [31:0] d; logic [4:0] e; logic [2:0] r; exp_t x;
    do_reset();
    iss_ready = '0;
    in_valid = 1'b1; in_unit = 3'd2;
    #1;
    vectors++;
    if (in_ready !== 1'b0) begin
      miscompares++; $display("[TB] FAIL blocked_unit in_ready: got %b, required 0", in_ready);
    end
    in_valid = 1'b0;
    do_issue(3'd6, RM_DYN, tag, iv);
    sb.push_back(mk(32'h0, 5'b10000, RM_DYN));
    iss_ready = '1;
    vectors++;
    if (iv !== 5'b00000) begin
      miscompares++; $display("[TB] FAIL invalid_no_issue iss_valid: got %b, required 00000", iv);
    end
    do_retire(d, e, r);
    x = sb.pop_front();
    vectors++;
    if ({d, e, r} !== {x.data, x.exc, x.rm}) begin
      miscompares++; $display("[TB] FAIL invalid_retire: got %h/%b/%b, required %h/%b/%b", d, e, r, x.data, x.exc, x.rm);
    end
    #1;
    vectors++;
    if (fflags !== 5'b10000) begin
      miscompares++; $display("[TB] FAIL invalid_fflags: got %b, required 10000", fflags);
    end
  endtask

  task automatic test_protocol_errors();
    logic [TAGW-1:0] tag; logic [NU-1:0] iv;
    logic [31:0] d; logic [4:0] e; logic [2:0] r; exp_t x;
    do_reset();
    do_issue(3'(UNIT_ADD_SUB), RM_RNE, tag, iv);
    do_issue(3'(UNIT_MUL), RM_RNE, tag, iv);
    do_complete(UNIT_DIV, 3'd3, 32'hDEAD_BEEF, 5'b11111);
    #1;
    vectors++;
    if ({err, out_valid, busy} !== 3'b101) begin
      miscompares++; $display("[TB] FAIL spurious_tag err/ov/busy: got %b/%b/%b, required 1/0/1", err, out_valid, busy);
    end
    do_reset();
    do_issue(3'(UNIT_ADD_SUB), RM_RNE, tag, iv);
    sb.push_back(mk(32'h0000_AAAA, 5'b01000, RM_RNE));
    do_issue(3'(UNIT_MUL), RM_RTZ, tag, iv);
    do_issue(3'(UNIT_MAC), RM_RUP, tag, iv);
    #1;
    vectors++;
    if (err !== 1'b0) begin
      miscompares++; $display("[TB] FAIL err_clean_before_dup: got %b, required 0", err);
    end
    cmp_valid = 5'b00011;
    cmp_tag[0 +: TAGW] = 3'd0;      cmp_tag[TAGW +: TAGW] = 3'd0;
    cmp_data[0 +: DW] = 32'h0000_AAAA; cmp_data[DW +: DW] = 32'h0000_BBBB;
    cmp_exc[0 +: 5] = 5'b01000;     cmp_exc[5 +: 5] = 5'b11111;
    @(negedge clk);
    cmp_valid = '0;
    #1;
    vectors++;
    if (err !== 1'b1) begin
      miscompares++; $display("[TB] FAIL dup_err: got %b, required 1", err);
    end
    do_retire(d, e, r);
    x = sb.pop_front();
    vectors++;
    if ({d, e, r} !== {x.data, x.exc, x.rm}) begin
      miscompares++; $display("[TB] FAIL dup_lowest_wins: got %h/%b/%b, required %h/%b/%b", d, e, r, x.data, x.exc, x.rm);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    sb.delete();
    cmp_valid[UNIT_ADD_SUB] = 1'b1;
    cmp_tag[0 +: TAGW] = 3'd1;
    #1;
    vectors++;
    if ({busy, out_valid, err, fflags} !== 8'd0) begin
      miscompares++; $display("[TB] FAIL reset_midflight busy/ov/err/fflags: got %b/%b/%b/%b, required 0/0/0/00000",
                              busy, out_valid, err, fflags);
    end
    @(negedge clk);
    cmp_valid = '0;
    #1;
    vectors++;
    if ({err, busy} !== 2'b10) begin
      miscompares++; $display("[TB] FAIL post_reset_spurious err/busy: got %b/%b, required 1/0", err, busy);
    end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_in_order();
    test_out_of_order();
    test_full();
    test_backpressure();
    test_invalid_unit();
    test_protocol_errors();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
